// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: turns single-byte commands popped from the UART rx FIFO into
// stopwatch run/clear controls, and streams a frozen time report (d2 d1 . d0
// followed by CR LF) into the UART tx FIFO.
module uart_cmd_ctrl #(
    parameter logic [7:0] CMD_GO   = 8'h67,
    parameter logic [7:0] CMD_STOP = 8'h73,
    parameter logic [7:0] CMD_CLR  = 8'h63,
    parameter logic [7:0] CMD_RPT  = 8'h72
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    input  logic       tx_full,
    output logic [7:0] w_data,
    output logic       wr_uart,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    output logic       go,
    output logic       clr,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_SEND   = 2'd2
    } state_t;

    // Report is six bytes; an unrecognised command answers with a single '?'.
    localparam logic [2:0] RPT_LEN = 3'd6;
    localparam logic [2:0] UNK_LEN = 3'd1;

    state_t      state_r, state_nxt_s;
    logic [7:0]  cmd_r, cmd_nxt_s;
    logic [11:0] snap_r, snap_nxt_s;
    logic [2:0]  idx_r, idx_nxt_s;
    logic [2:0]  len_r, len_nxt_s;
    logic        go_r, go_nxt_s;
    logic        clr_r, clr_nxt_s;
    logic        rd_uart_s;
    logic        wr_uart_s;
    logic [7:0]  w_data_s;

    // ASCII for one nibble; values above 9 print as letters so bad BCD is visible.
    function automatic logic [7:0] hex_char(input logic [3:0] x);
        logic [7:0] ch;
        if (x <= 4'd9) begin
            ch = 8'h30 + {4'h0, x};
        end else begin
            ch = 8'h41 + ({4'h0, x} - 8'd10);
        end
        return ch;
    endfunction

    // Byte at position idx of the outgoing message built from the snapshot.
    function automatic logic [7:0] send_byte(input logic [11:0] snap,
                                             input logic [2:0]  idx,
                                             input logic [2:0]  len);
        logic [7:0] b;
        if (len == UNK_LEN) begin
            b = 8'h3F;
        end else begin
            case (idx)
                3'd0:    b = hex_char(snap[11:8]);
                3'd1:    b = hex_char(snap[7:4]);
                3'd2:    b = 8'h2E;
                3'd3:    b = hex_char(snap[3:0]);
                3'd4:    b = 8'h0D;
                3'd5:    b = 8'h0A;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

    // Next-state, datapath next values and the combinational FIFO strobes.
    always_comb begin
        state_nxt_s = state_r;
        cmd_nxt_s   = cmd_r;
        snap_nxt_s  = snap_r;
        idx_nxt_s   = idx_r;
        len_nxt_s   = len_r;
        go_nxt_s    = go_r;
        clr_nxt_s   = 1'b0;
        rd_uart_s   = 1'b0;
        wr_uart_s   = 1'b0;
        w_data_s    = 8'h00;

        case (state_r)
            ST_IDLE: begin
                if (!rx_empty) begin
                    rd_uart_s   = 1'b1;
                    cmd_nxt_s   = r_data;
                    state_nxt_s = ST_DECODE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DECODE: begin
                case (cmd_r)
                    CMD_GO: begin
                        go_nxt_s    = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                    CMD_STOP: begin
                        go_nxt_s    = 1'b0;
                        state_nxt_s = ST_IDLE;
                    end
                    CMD_CLR: begin
                        clr_nxt_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                    CMD_RPT: begin
                        snap_nxt_s  = {d2, d1, d0};
                        idx_nxt_s   = 3'd0;
                        len_nxt_s   = RPT_LEN;
                        state_nxt_s = ST_SEND;
                    end
                    default: begin
                        idx_nxt_s   = 3'd0;
                        len_nxt_s   = UNK_LEN;
                        state_nxt_s = ST_SEND;
                    end
                endcase
            end
            ST_SEND: begin
                // Data depends only on registered snapshot/index, so it holds during a stall.
                w_data_s = send_byte(snap_r, idx_r, len_r);
                if (!tx_full) begin
                    wr_uart_s = 1'b1;
                    if (idx_r == (len_r - 3'd1)) begin
                        idx_nxt_s   = 3'd0;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        idx_nxt_s   = idx_r + 3'd1;
                        state_nxt_s = ST_SEND;
                    end
                end else begin
                    wr_uart_s   = 1'b0;
                    state_nxt_s = ST_SEND;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cmd_r   <= 8'h00;
            snap_r  <= 12'h000;
            idx_r   <= 3'd0;
            len_r   <= 3'd0;
            go_r    <= 1'b0;
            clr_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cmd_r   <= cmd_nxt_s;
            snap_r  <= snap_nxt_s;
            idx_r   <= idx_nxt_s;
            len_r   <= len_nxt_s;
            go_r    <= go_nxt_s;
            clr_r   <= clr_nxt_s;
        end
    end

    assign rd_uart = rd_uart_s;
    assign wr_uart = wr_uart_s;
    assign w_data  = w_data_s;
    assign go      = go_r;
    assign clr     = clr_r;
    assign busy    = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed scenarios plus a randomized
// phase, all checked against a transaction-level reference model.
module tb_uart_cmd_ctrl;

    localparam logic [7:0] CMD_GO   = 8'h67;
    localparam logic [7:0] CMD_STOP = 8'h73;
    localparam logic [7:0] CMD_CLR  = 8'h63;
    localparam logic [7:0] CMD_RPT  = 8'h72;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       rx_empty = 1'b1;
    logic [7:0] r_data   = 8'h00;
    logic       rd_uart;
    logic       tx_full  = 1'b0;
    logic [7:0] w_data;
    logic       wr_uart;
    logic [3:0] d2 = 4'd0;
    logic [3:0] d1 = 4'd0;
    logic [3:0] d0 = 4'd0;
    logic       go;
    logic       clr;
    logic       busy;

    uart_cmd_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .rx_empty (rx_empty),
        .r_data   (r_data),
        .rd_uart  (rd_uart),
        .tx_full  (tx_full),
        .w_data   (w_data),
        .wr_uart  (wr_uart),
        .d2       (d2),
        .d1       (d1),
        .d0       (d0),
        .go       (go),
        .clr      (clr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // bench-side FIFOs and reference model state
    logic [7:0] rxq[$];
    logic [7:0] exp_tx[$];
    logic [7:0] got_tx[$];
    logic       m_go  = 1'b0;
    logic       m_clr = 1'b0;
    int         m_phase = 0;   // 0 idle, 1 command popped, 2 sending
    int         m_left  = 0;
    logic [7:0] m_cmd   = 8'h00;
    int         busy_cnt = 0;
    int         clr_cnt  = 0;
    string      hex_digits = "0123456789ABCDEF";

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ascii_of(input logic [3:0] x);
        return hex_digits[x];
    endfunction

    task automatic refresh_rx();
        rx_empty = (rxq.size() == 0);
        r_data   = rx_empty ? 8'h00 : rxq[0];
    endtask

    task automatic push_rx(input logic [7:0] b);
        rxq.push_back(b);
        refresh_rx();
    endtask

    // Reference model and bench FIFOs advance on every clock edge
    always @(posedge clk) begin : model_p
        logic rd_s;
        logic wr_s;
        logic [7:0] wd_s;
        rd_s = rd_uart;
        wr_s = wr_uart;
        wd_s = w_data;
        if (wr_s) got_tx.push_back(wd_s);
        m_clr = 1'b0;
        if (reset) begin
            m_go    = 1'b0;
            m_phase = 0;
            m_left  = 0;
            exp_tx.delete();
        end else if (rd_s && rxq.size() > 0) begin
            m_cmd   = rxq[0];
            m_phase = 1;
        end else if (m_phase == 1) begin
            case (m_cmd)
                CMD_GO:   begin m_go = 1'b1; m_phase = 0; end
                CMD_STOP: begin m_go = 1'b0; m_phase = 0; end
                CMD_CLR:  begin m_clr = 1'b1; m_phase = 0; end
                CMD_RPT: begin
                    exp_tx.push_back(ascii_of(d2));
                    exp_tx.push_back(ascii_of(d1));
                    exp_tx.push_back(8'h2E);
                    exp_tx.push_back(ascii_of(d0));
                    exp_tx.push_back(8'h0D);
                    exp_tx.push_back(8'h0A);
                    m_left  = 6;
                    m_phase = 2;
                end
                default: begin
                    exp_tx.push_back(8'h3F);
                    m_left  = 1;
                    m_phase = 2;
                end
            endcase
        end else if (m_phase == 2 && wr_s) begin
            if (exp_tx.size() > 0) void'(exp_tx.pop_front());
            m_left--;
            if (m_left == 0) m_phase = 0;
        end
        #1;
        if (rd_s && rxq.size() > 0) void'(rxq.pop_front());
        refresh_rx();
    end

    // Advance one cycle and compare every output against the model
    task automatic cycle();
        @(negedge clk);
        if (busy) busy_cnt++;
        if (clr) clr_cnt++;
        check_val("go", go, m_go);
        check_val("clr", clr, m_clr);
        check_val("busy", busy, m_phase != 0);
        check_val("rd_uart", rd_uart, (m_phase == 0) && !rx_empty);
        check_val("wr_uart", wr_uart, (m_phase == 2) && !tx_full);
        if (wr_uart && exp_tx.size() > 0) check_val("w_data", w_data, exp_tx[0]);
    endtask

    task automatic wait_idle(input int max_cycles);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            cycle();
            if (m_phase == 0 && rxq.size() == 0) done = 1'b1;
        end
        check_val("idle_timeout", done, 1'b1);
    endtask

    task automatic check_report(input string tag, input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] c);
        logic [7:0] ref_bytes[6];
        ref_bytes[0] = 8'h30 + {4'h0, a};
        ref_bytes[1] = 8'h30 + {4'h0, b};
        ref_bytes[2] = 8'h2E;
        ref_bytes[3] = 8'h30 + {4'h0, c};
        ref_bytes[4] = 8'h0D;
        ref_bytes[5] = 8'h0A;
        check_val({tag, "_len"}, got_tx.size(), 6);
        for (int i = 0; i < 6 && i < got_tx.size(); i++)
            check_val(tag, got_tx[i], ref_bytes[i]);
    endtask

    initial begin
        repeat (2) cycle();
        reset = 1'b0;

        // idle with empty rx FIFO
        for (int i = 0; i < 20; i++) begin
            cycle();
            check_val("idle_outs", {go, clr, rd_uart, wr_uart, busy}, 5'b00000);
        end
        check_val("idle_wdata", w_data, 8'h00);

        // go then stop
        push_rx(CMD_GO);
        wait_idle(20);
        check_val("go_set", go, 1'b1);
        push_rx(CMD_STOP);
        wait_idle(20);
        check_val("go_clear", go, 1'b0);

        // clear pulse while running
        push_rx(CMD_GO);
        wait_idle(20);
        clr_cnt = 0;
        push_rx(CMD_CLR);
        wait_idle(20);
        check_val("clr_pulses", clr_cnt, 1);
        check_val("go_kept", go, 1'b1);

        // report with digits changing mid-report
        push_rx(CMD_STOP);
        wait_idle(20);
        d2 = 4'd1; d1 = 4'd2; d0 = 4'd3;
        got_tx.delete();
        busy_cnt = 0;
        push_rx(CMD_RPT);
        repeat (4) cycle();
        d2 = 4'd4; d1 = 4'd5; d0 = 4'd6;
        wait_idle(30);
        check_report("rpt_bytes", 4'd1, 4'd2, 4'd3);
        check_val("rpt_busy_cycles", busy_cnt, 7);

        // report stalled three cycles after second byte, 'g' queued meanwhile
        d2 = 4'd1; d1 = 4'd2; d0 = 4'd3;
        got_tx.delete();
        busy_cnt = 0;
        push_rx(CMD_RPT);
        for (int i = 0; i < 20 && got_tx.size() < 2; i++) cycle();
        tx_full = 1'b1;
        push_rx(CMD_GO);
        repeat (3) cycle();
        tx_full = 1'b0;
        wait_idle(30);
        check_report("stall_bytes", 4'd1, 4'd2, 4'd3);
        // seven report cycles, three stall cycles, one decode cycle for 'g'
        check_val("stall_busy_cycles", busy_cnt, 11);
        check_val("queued_go", go, 1'b1);

        // unknown byte
        got_tx.delete();
        busy_cnt = 0;
        push_rx(8'h78);
        wait_idle(20);
        check_val("unk_len", got_tx.size(), 1);
        if (got_tx.size() > 0) check_val("unk_byte", got_tx[0], 8'h3F);
        check_val("unk_busy_cycles", busy_cnt, 2);

        // reset in the cycle of the third report byte
        got_tx.delete();
        push_rx(CMD_RPT);
        for (int i = 0; i < 20 && !(wr_uart && got_tx.size() == 2); i++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (10) cycle();
        check_val("rst_bytes", got_tx.size(), 3);
        check_val("rst_go", go, 1'b0);
        check_val("rst_busy", busy, 1'b0);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0 && rxq.size() < 4) begin
                case ($urandom_range(0, 4))
                    0: push_rx(CMD_GO);
                    1: push_rx(CMD_STOP);
                    2: push_rx(CMD_CLR);
                    3: push_rx(CMD_RPT);
                    default: push_rx(8'($urandom_range(0, 255)));
                endcase
            end
            tx_full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                d2 = 4'($urandom_range(0, 15));
                d1 = 4'($urandom_range(0, 15));
                d0 = 4'($urandom_range(0, 15));
            end
            cycle();
        end
        tx_full = 1'b0;
        wait_idle(300);
        check_val("exp_tx_drained", exp_tx.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
